// File: rtl/demux_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : demux_scheduler
//  Description : Feeds a 2:1 demux stage from a single byte stream. Words are
//                steered round-robin between side 0 and side 1, skipping a
//                paused side. A one-entry holding buffer absorbs stalls when
//                both sides are paused; backpressure reaches the source via
//                ready_out. Per-side dispatch counters are kept for debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_scheduler #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              pause0,
    input  logic              pause1,
    output logic [DATA_W-1:0] data_to_demux,
    output logic              valid_to_demux,
    output logic              selector,
    output logic [CNT_W-1:0]  count0,
    output logic [CNT_W-1:0]  count1,
    output logic              busy
);

    // Holding-buffer occupancy: EMPTY means no word waiting, HOLD means one.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_buf_data;
    logic                r_last_sel;

    logic                w_buf_valid;
    logic                w_pref;
    logic                w_pref_paused;
    logic                w_target;
    logic                w_can_dispatch;
    logic                w_accept;

    // Dispatch decision: the side not used last is preferred; if it is paused
    // the other side is taken; if both are paused the buffered word waits.
    // ready_out only looks at registered state and the pause/enable inputs so
    // that it never forms a loop through the source's valid_in.
    always_comb begin
        w_buf_valid    = (r_state == HOLD);
        w_pref         = ~r_last_sel;
        w_pref_paused  = w_pref ? pause1 : pause0;
        w_target       = w_pref_paused ? ~w_pref : w_pref;
        w_can_dispatch = en & w_buf_valid & ~(pause0 & pause1);
        ready_out      = en & (~w_buf_valid | w_can_dispatch);
        w_accept       = valid_in & ready_out;
    end

    assign busy = w_buf_valid;

    // Buffer FSM: a new word may replace the buffered one only on the same
    // edge that the buffered word leaves, so nothing is ever overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_buf_data <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_buf_data <= data_in;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_buf_data <= data_in;
                    end else if (w_can_dispatch) begin
                        r_state <= EMPTY;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    // Registered demux interface: a one-cycle valid pulse per dispatch, with
    // selector and data holding their last values between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_to_demux <= 1'b0;
            selector       <= 1'b0;
            data_to_demux  <= '0;
            r_last_sel     <= 1'b1;
        end else if (w_can_dispatch) begin
            valid_to_demux <= 1'b1;
            selector       <= w_target;
            data_to_demux  <= r_buf_data;
            r_last_sel     <= w_target;
        end else begin
            valid_to_demux <= 1'b0;
        end
    end

    // Per-side dispatch counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count0 <= '0;
            count1 <= '0;
        end else if (w_can_dispatch) begin
            if (w_target) begin
                count1 <= count1 + 1'b1;
            end else begin
                count0 <= count0 + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
